// File: rtl/arith_pkg.sv
// arith_pkg: shared widths, opcodes and controller state type for the
// arithmetic command sequencer.
package arith_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RES_W  = 64;
  localparam int unsigned CNT_W  = 16;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;
  localparam logic [OP_W-1:0] OP_MOD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/arith_lat_sel.sv
// arith_lat_sel: combinational decode of an opcode into its latency window
// (stored as LAT-1 for the down-counter), an illegal-op flag and a
// divider-class flag used for the divide-by-zero check.
//   op      in   opcode
//   lat_m1  out  latency minus one for the opcode
//   illegal out  opcode is outside ADD..MOD
//   is_div  out  opcode is DIV or MOD
module arith_lat_sel
  import arith_pkg::*;
#(
  parameter int unsigned ADDSUB_LAT = 1,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned DIV_LAT    = 8
) (
  input  logic [OP_W-1:0]  op,
  output logic [CNT_W-1:0] lat_m1,
  output logic             illegal,
  output logic             is_div
);

  always_comb begin
    lat_m1  = '0;
    illegal = 1'b0;
    is_div  = 1'b0;
    case (op)
      OP_ADD, OP_SUB: lat_m1 = CNT_W'(ADDSUB_LAT - 1);
      OP_MUL:         lat_m1 = CNT_W'(MUL_LAT - 1);
      OP_DIV, OP_MOD: begin
        lat_m1 = CNT_W'(DIV_LAT - 1);
        is_div = 1'b1;
      end
      default:        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/arith_op_sequencer.sv
// arith_op_sequencer: single-issue controller for the add/sub, multiply,
// divide and modulo units. Accepts one command over valid/ready, holds the
// latched operands for the unit's latency window, registers the 64-bit
// result and flags, and returns them over a valid/ready response channel.
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_op, cmd_a, cmd_b  opcode (0..4 legal) and 32-bit operands
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              64-bit result
//   rsp_carry, rsp_ovf    adder carry-out / signed overflow (ADD/SUB only)
//   rsp_error             divide-by-zero or illegal opcode
//   op_count              completed responses, wraps silently
module arith_op_sequencer
  import arith_pkg::*;
#(
  parameter int unsigned ADDSUB_LAT = 1,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned DIV_LAT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_carry,
  output logic              rsp_ovf,
  output logic              rsp_error,
  output logic [15:0]       op_count
);

  state_t              state;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [CNT_W-1:0]    lat_cnt;
  logic [RES_W-1:0]    data_q;
  logic                carry_q;
  logic                ovf_q;
  logic                err_q;
  logic [15:0]         op_count_q;

  logic [CNT_W-1:0]    lat_m1;
  logic                illegal;
  logic                is_div;
  logic                bad_cmd;

  arith_lat_sel #(
    .ADDSUB_LAT (ADDSUB_LAT),
    .MUL_LAT    (MUL_LAT),
    .DIV_LAT    (DIV_LAT)
  ) u_lat_sel (
    .op      (cmd_op),
    .lat_m1  (lat_m1),
    .illegal (illegal),
    .is_div  (is_div)
  );

  // Full-width zero check on the divisor decides the error path at accept time.
  assign bad_cmd = illegal || (is_div && (cmd_b == '0));

  // Arithmetic units, fed only from the latched operand registers.
  logic                sub_sel;
  logic [DATA_W-1:0]   b_eff;
  logic [DATA_W:0]     sum_full;
  logic                c31;
  logic [RES_W-1:0]    prod;
  logic [DATA_W-1:0]   b_div;
  logic [DATA_W-1:0]   quot;
  logic [DATA_W-1:0]   rem;

  assign sub_sel  = (op_q == OP_SUB);
  assign b_eff    = sub_sel ? ~b_q : b_q;
  assign sum_full = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_sel};
  // Carry into the sign bit, recovered from the sum bit and its inputs.
  assign c31      = a_q[DATA_W-1] ^ b_eff[DATA_W-1] ^ sum_full[DATA_W-1];
  assign prod     = RES_W'(a_q) * RES_W'(b_q);
  // Divisor is never zero here on a real op; the guard only keeps the
  // divider well-defined while idle registers hold zero.
  assign b_div    = (b_q == '0) ? DATA_W'(1) : b_q;
  assign quot     = a_q / b_div;
  assign rem      = a_q % b_div;

  logic [RES_W-1:0]    unit_data;
  logic                unit_carry;
  logic                unit_ovf;

  always_comb begin
    unit_data  = '0;
    unit_carry = 1'b0;
    unit_ovf   = 1'b0;
    case (op_q)
      OP_ADD, OP_SUB: begin
        unit_data  = {{(RES_W-DATA_W){1'b0}}, sum_full[DATA_W-1:0]};
        unit_carry = sum_full[DATA_W];
        unit_ovf   = sum_full[DATA_W] ^ c31;
      end
      OP_MUL:  unit_data = prod;
      OP_DIV:  unit_data = {{(RES_W-DATA_W){1'b0}}, quot};
      OP_MOD:  unit_data = {{(RES_W-DATA_W){1'b0}}, rem};
      default: unit_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      lat_cnt    <= '0;
      data_q     <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            a_q     <= cmd_a;
            b_q     <= cmd_b;
            data_q  <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= bad_cmd;
            if (bad_cmd) begin
              state <= ST_RESP;
            end else begin
              lat_cnt <= lat_m1;
              state   <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (lat_cnt == '0) begin
            data_q  <= unit_data;
            carry_q <= unit_carry;
            ovf_q   <= unit_ovf;
            state   <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            op_count_q <= op_count_q + 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_data  = data_q;
  assign rsp_carry = carry_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_error = err_q;
  assign op_count  = op_count_q;

endmodule
